noc_link_tx_arbiter: RTL and testbench
======================================

// Module: noc_link_tx_arbiter
// PURPOSE
// Shares the write side of the off-chip NoC async-FIFO link (data/waddr out, raddr in) among NUM_REQ
// local NoC sources. Round-robin arbitration with packet locking: a granted source keeps the link until its
// last flit. Owns the gray-coded write pointer, synchronises the remote read pointer, and blocks on full.
// PARAMETERS
// NUM_REQ      4   number of requesting sources (2..8)
// PACKET_SIZE  64  flit width in bits (set to NOC_ASYNC_FIFO_PACKET_SIZE at instantiation)
// AWIDTH       3   FIFO address width; depth = 2**AWIDTH, pointers are AWIDTH+1 bits
// PORTS
// clk_i              in   1                  link-side clock
// reset_n_i          in   1                  asynchronous reset, active low
// enable_i           in   1                  permits new grants
// req_valid_i        in   NUM_REQ            flit valid per source
// req_last_i         in   NUM_REQ            flit is last of packet
// req_data_i         in   NUM_REQ*PACKET_SIZE  flits, source i at [i*PACKET_SIZE +: PACKET_SIZE]
// req_ready_o        out  NUM_REQ            flit accepted this cycle when valid&ready
// fifo_wen_o         out  1                  write strobe to FIFO memory
// fifo_waddr_o       out  AWIDTH             memory write address (binary)
// fifo_wdata_o       out  PACKET_SIZE        memory write data
// fifo_wptr_gray_o   out  AWIDTH+1           write pointer, gray, registered (to read domain)
// fifo_rptr_gray_i   in   AWIDTH+1           read pointer, gray, asynchronous (from read domain)
// fifo_full_o        out  1                  FIFO full against synchronised read pointer
// grant_o            out  NUM_REQ            one-hot current owner, 0 when idle
// pkt_cnt_o          out  16                 completed packets, wraps 0xFFFF->0
// BEHAVIOUR
// - Reset (async, reset_n_i=0): state IDLE, grant_o=0, rr_ptr=0, wptr bin/gray=0, 2-flop sync regs=0,
//   pkt_cnt_o=0; req_ready_o=0, fifo_wen_o=0, fifo_full_o=0 via comb. Reset mid-packet aborts it; no flush.
// - rptr sync: 2 flops on clk_i; full = wgray == {~rsync[AWIDTH:AWIDTH-1], rsync[AWIDTH-2:0]}.
// - FSM IDLE: if enable_i and |req_valid_i: winner = first valid at/after rr_ptr (modulo NUM_REQ);
//   grant_o<=onehot(winner), ->LOCKED. Else stay. Arbitration latency 1 cycle; no flit accepted in IDLE.
// - FSM LOCKED: req_ready_o = grant_o & {NUM_REQ{~full}}; others 0. xfer = |(req_valid_i & req_ready_o).
//   xfer with req_last_i[winner]: ->IDLE, grant_o<=0, rr_ptr<=winner+1 (wrap), pkt_cnt_o+=1.
//   One idle bubble between packets is mandatory.
// - enable_i=0 in LOCKED does not stall; current packet completes, then no new grant.
// - Write path (comb, same cycle as xfer): fifo_wen_o=xfer, fifo_waddr_o=wbin[AWIDTH-1:0],
//   fifo_wdata_o=req_data_i slice of winner (0 when idle). On xfer edge: wbin+=1 (wraps at 2**(AWIDTH+1)),
//   wgray<=bin2gray(wbin+1). Pointer becomes visible the cycle after the memory write.
// - Full: ready drops same cycle full asserts; grant held; resumes without re-arbitration once the
//   synchronised rptr advances (>=2 cycles after remote update).
// - Source deasserting valid mid-packet keeps the lock (no timeout).
// - req_valid_i of non-granted sources is ignored; they are never readied.
// TESTING
// T1 reset: reset_n_i=0 mid-packet -> all outputs 0 immediately; after release, wptr_gray=0, pkt_cnt=0.
// T2 single: src2 sends 3 flits (last on 3rd), FIFO empty -> grant_o=4'b0100 1 cycle after valid,
//   3 wen at waddr 0,1,2, wptr_gray=3'b... 4'b0010 after, pkt_cnt=1, back to IDLE.
// T3 round robin: all 4 valid, 1-flit packets -> grant order 0,1,2,3,0 with one idle cycle between each.
// T4 full: AWIDTH=3, rptr held 0 -> 8 flits written, 9th stalls (ready=0, full=1); rptr_gray set to 1 ->
//   ready reasserts exactly 2 cycles later, 9th written at waddr 0, wptr wraps bin 8->9.
// T5 lock: src0 pkt of 4 with valid gap after flit 2 while src1 valid -> src1 ungranted until src0 last.
// T6 enable: enable_i=0 during src3 packet -> packet completes, then no grant while src1 valid.

Source files
------------

// File: rtl/noc_link_tx_arbiter.sv
// Round-robin, packet-locked arbiter driving the write side of the
// off-chip NoC async-FIFO link; owns the gray write pointer.
module noc_link_tx_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int PACKET_SIZE = 64,
  parameter int AWIDTH      = 3
) (
  input  logic                           clk_i,
  input  logic                           reset_n_i,
  input  logic                           enable_i,
  input  logic [NUM_REQ-1:0]             req_valid_i,
  input  logic [NUM_REQ-1:0]             req_last_i,
  input  logic [NUM_REQ*PACKET_SIZE-1:0] req_data_i,
  output logic [NUM_REQ-1:0]             req_ready_o,
  output logic                           fifo_wen_o,
  output logic [AWIDTH-1:0]              fifo_waddr_o,
  output logic [PACKET_SIZE-1:0]         fifo_wdata_o,
  output logic [AWIDTH:0]                fifo_wptr_gray_o,
  input  logic [AWIDTH:0]                fifo_rptr_gray_i,
  output logic                           fifo_full_o,
  output logic [NUM_REQ-1:0]             grant_o,
  output logic [15:0]                    pkt_cnt_o
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int PW = AWIDTH + 1;

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [IW-1:0]      win_q, win_d;
  logic [IW-1:0]      rr_q, rr_d;
  logic [IW-1:0]      arb_idx, win_inc;
  logic               arb_found;
  logic [PW-1:0]      wbin_q, wgray_q;
  logic [PW-1:0]      rsync1_q, rsync2_q;
  logic [PW-1:0]      wbin_inc;
  logic [15:0]        pkt_q;
  logic               full, xfer, done;
  int                 cand;

  assign full = wgray_q == {~rsync2_q[AWIDTH:AWIDTH-1],
                            rsync2_q[AWIDTH-2:0]};

  assign wbin_inc = wbin_q + PW'(1);
  assign win_inc  = (win_q == IW'(NUM_REQ - 1)) ? '0
                                               : win_q + IW'(1);

  // first valid source at or after rr_q, wrapping
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    cand      = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = (int'(rr_q) + k) % NUM_REQ;
      if (!arb_found && req_valid_i[IW'(cand)]) begin
        arb_found = 1'b1;
        arb_idx   = IW'(cand);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    win_d       = win_q;
    rr_d        = rr_q;
    req_ready_o = '0;
    xfer        = 1'b0;
    done        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (enable_i && arb_found) begin
          state_d = LOCKED;
          grant_d = NUM_REQ'(1) << arb_idx;
          win_d   = arb_idx;
        end
      end
      LOCKED: begin
        req_ready_o = grant_q & {NUM_REQ{~full}};
        xfer        = |(req_valid_i & req_ready_o);
        done        = xfer && req_last_i[win_q];
        if (done) begin
          state_d = IDLE;
          grant_d = '0;
          rr_d    = win_inc;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    fifo_wdata_o = '0;
    if (state_q == LOCKED) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (win_q == IW'(i))
          fifo_wdata_o = req_data_i[i*PACKET_SIZE +: PACKET_SIZE];
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      win_q    <= '0;
      rr_q     <= '0;
      wbin_q   <= '0;
      wgray_q  <= '0;
      rsync1_q <= '0;
      rsync2_q <= '0;
      pkt_q    <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      win_q    <= win_d;
      rr_q     <= rr_d;
      rsync1_q <= fifo_rptr_gray_i;
      rsync2_q <= rsync1_q;
      if (xfer) begin
        wbin_q  <= wbin_inc;
        wgray_q <= wbin_inc ^ (wbin_inc >> 1);
      end
      if (done)
        pkt_q <= pkt_q + 16'd1;
    end
  end

  assign fifo_wen_o       = xfer;
  assign fifo_waddr_o     = wbin_q[AWIDTH-1:0];
  assign fifo_wptr_gray_o = wgray_q;
  assign fifo_full_o      = full;
  assign grant_o          = grant_q;
  assign pkt_cnt_o        = pkt_q;

endmodule

// File: tb/tb_noc_link_tx_arbiter.sv
// Directed bench for noc_link_tx_arbiter: reset, single packet,
// round robin, full/wrap, packet lock and enable gating.
module tb_noc_link_tx_arbiter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         enable;
  logic [3:0]   valid, last;
  logic [255:0] data;
  logic [3:0]   ready;
  logic         wen;
  logic [2:0]   waddr;
  logic [63:0]  wdata;
  logic [3:0]   wgray;
  logic [3:0]   rptr;
  logic         full;
  logic [3:0]   grant;
  logic [15:0]  pkt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  noc_link_tx_arbiter #(
    .NUM_REQ(4), .PACKET_SIZE(64), .AWIDTH(3)
  ) dut (
    .clk_i            (clk),
    .reset_n_i        (rst_n),
    .enable_i         (enable),
    .req_valid_i      (valid),
    .req_last_i       (last),
    .req_data_i       (data),
    .req_ready_o      (ready),
    .fifo_wen_o       (wen),
    .fifo_waddr_o     (waddr),
    .fifo_wdata_o     (wdata),
    .fifo_wptr_gray_o (wgray),
    .fifo_rptr_gray_i (rptr),
    .fifo_full_o      (full),
    .grant_o          (grant),
    .pkt_cnt_o        (pkt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    enable = 1'b1;
    valid  = '0;
    last   = '0;
    data   = '0;
    rptr   = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL t1_grant got %b want 0000", grant); end
    checks++; if (wgray !== 4'b0000) begin errors++; $display("FAIL t1_wgray got %b want 0000", wgray); end
    checks++; if (pkt !== 16'd0) begin errors++; $display("FAIL t1_pkt got %0d want 0", pkt); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL t1_full got %b want 0", full); end
    checks++; if (ready !== 4'b0000) begin errors++; $display("FAIL t1_ready got %b want 0000", ready); end
    checks++; if (wen !== 1'b0) begin errors++; $display("FAIL t1_wen got %b want 0", wen); end
    valid = 4'b0010;
    data[1*64 +: 64] = 64'h11;
    step();
    checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL t1_grant1 got %b want 0010", grant); end
    checks++; if (wen !== 1'b1) begin errors++; $display("FAIL t1_wen1 got %b want 1", wen); end
    step();
    checks++; if (wgray !== 4'b0001) begin errors++; $display("FAIL t1_wgray1 got %b want 0001", wgray); end
    rst_n = 1'b0;
    #1;
    checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL t1_rgrant got %b want 0000", grant); end
    checks++; if (ready !== 4'b0000) begin errors++; $display("FAIL t1_rready got %b want 0000", ready); end
    checks++; if (wen !== 1'b0) begin errors++; $display("FAIL t1_rwen got %b want 0", wen); end
    checks++; if (wgray !== 4'b0000) begin errors++; $display("FAIL t1_rwgray got %b want 0000", wgray); end
    rst_n = 1'b1;
    #1;
    checks++; if (pkt !== 16'd0) begin errors++; $display("FAIL t1_rpkt got %0d want 0", pkt); end
    valid = '0;
  endtask

  task automatic test_single();
    do_reset();
    valid = 4'b0100;
    data[2*64 +: 64] = 64'h2000;
    #1;
    checks++; if (ready !== 4'b0000) begin errors++; $display("FAIL t2_idle_ready got %b want 0000", ready); end
    checks++; if (wen !== 1'b0) begin errors++; $display("FAIL t2_idle_wen got %b want 0", wen); end
    step();
    for (int f = 0; f < 3; f++) begin
      data[2*64 +: 64] = 64'h2000 + 64'(f);
      last = (f == 2) ? 4'b0100 : 4'b0000;
      #1;
      checks++; if (grant !== 4'b0100) begin errors++; $display("FAIL t2_grant%0d got %b want 0100", f, grant); end
      checks++; if (wen !== 1'b1) begin errors++; $display("FAIL t2_wen%0d got %b want 1", f, wen); end
      checks++; if (waddr !== 3'(f)) begin errors++; $display("FAIL t2_waddr%0d got %0d want %0d", f, waddr, f); end
      checks++; if (wdata !== 64'h2000 + 64'(f)) begin errors++; $display("FAIL t2_wdata%0d got %h want %h", f, wdata, 64'h2000 + 64'(f)); end
      step();
    end
    valid = '0;
    last  = '0;
    #1;
    checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL t2_grant_end got %b want 0000", grant); end
    checks++; if (pkt !== 16'd1) begin errors++; $display("FAIL t2_pkt got %0d want 1", pkt); end
    checks++; if (wgray !== 4'b0010) begin errors++; $display("FAIL t2_wgray got %b want 0010", wgray); end
    checks++; if (wen !== 1'b0) begin errors++; $display("FAIL t2_wen_end got %b want 0", wen); end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_g;
    do_reset();
    for (int i = 0; i < 4; i++) data[i*64 +: 64] = 64'hA0 + 64'(i);
    valid = 4'b1111;
    last  = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      step();
      exp_g = 4'b0001 << (k % 4);
      checks++; if (grant !== exp_g) begin errors++; $display("FAIL t3_grant%0d got %b want %b", k, grant, exp_g); end
      checks++; if (wen !== 1'b1) begin errors++; $display("FAIL t3_wen%0d got %b want 1", k, wen); end
      checks++; if (waddr !== 3'(k)) begin errors++; $display("FAIL t3_waddr%0d got %0d want %0d", k, waddr, k); end
      checks++; if (wdata !== 64'hA0 + 64'(k % 4)) begin errors++; $display("FAIL t3_wdata%0d got %h want %h", k, wdata, 64'hA0 + 64'(k % 4)); end
      step();
      checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL t3_bubble%0d got %b want 0000", k, grant); end
      checks++; if (wen !== 1'b0) begin errors++; $display("FAIL t3_bwen%0d got %b want 0", k, wen); end
    end
    valid = '0;
    last  = '0;
    checks++; if (pkt !== 16'd5) begin errors++; $display("FAIL t3_pkt got %0d want 5", pkt); end
  endtask

  task automatic test_full();
    do_reset();
    valid = 4'b0001;
    step();
    for (int f = 0; f < 8; f++) begin
      data[63:0] = 64'h4000 + 64'(f);
      #1;
      checks++; if (ready !== 4'b0001) begin errors++; $display("FAIL t4_ready%0d got %b want 0001", f, ready); end
      checks++; if (waddr !== 3'(f)) begin errors++; $display("FAIL t4_waddr%0d got %0d want %0d", f, waddr, f); end
      checks++; if (full !== 1'b0) begin errors++; $display("FAIL t4_full%0d got %b want 0", f, full); end
      step();
    end
    checks++; if (ready !== 4'b0000) begin errors++; $display("FAIL t4_stall_ready got %b want 0000", ready); end
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL t4_stall_full got %b want 1", full); end
    checks++; if (wen !== 1'b0) begin errors++; $display("FAIL t4_stall_wen got %b want 0", wen); end
    checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL t4_stall_grant got %b want 0001", grant); end
    checks++; if (wgray !== 4'b1100) begin errors++; $display("FAIL t4_wgray8 got %b want 1100", wgray); end
    rptr = 4'b0001;
    step();
    checks++; if (ready !== 4'b0000) begin errors++; $display("FAIL t4_sync1_ready got %b want 0000", ready); end
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL t4_sync1_full got %b want 1", full); end
    data[63:0] = 64'h4008;
    last = 4'b0001;
    step();
    checks++; if (ready !== 4'b0001) begin errors++; $display("FAIL t4_resume_ready got %b want 0001", ready); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL t4_resume_full got %b want 0", full); end
    checks++; if (wen !== 1'b1) begin errors++; $display("FAIL t4_resume_wen got %b want 1", wen); end
    checks++; if (waddr !== 3'd0) begin errors++; $display("FAIL t4_resume_waddr got %0d want 0", waddr); end
    checks++; if (wdata !== 64'h4008) begin errors++; $display("FAIL t4_resume_wdata got %h want 4008", wdata); end
    step();
    checks++; if (wgray !== 4'b1101) begin errors++; $display("FAIL t4_wgray9 got %b want 1101", wgray); end
    checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL t4_end_grant got %b want 0000", grant); end
    checks++; if (pkt !== 16'd1) begin errors++; $display("FAIL t4_pkt got %0d want 1", pkt); end
    valid = '0;
    last  = '0;
  endtask

  task automatic test_lock();
    do_reset();
    valid = 4'b0011;
    data[63:0]   = 64'h5000;
    data[127:64] = 64'h5100;
    step();
    checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL t5_grant got %b want 0001", grant); end
    checks++; if (ready !== 4'b0001) begin errors++; $display("FAIL t5_ready got %b want 0001", ready); end
    checks++; if (wdata !== 64'h5000) begin errors++; $display("FAIL t5_wdata0 got %h want 5000", wdata); end
    step();
    data[63:0] = 64'h5001;
    step();
    valid = 4'b0010;
    #1;
    checks++; if (wen !== 1'b0) begin errors++; $display("FAIL t5_gap_wen got %b want 0", wen); end
    checks++; if (ready !== 4'b0001) begin errors++; $display("FAIL t5_gap_ready got %b want 0001", ready); end
    step();
    checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL t5_gap_grant got %b want 0001", grant); end
    step();
    valid = 4'b0011;
    data[63:0] = 64'h5002;
    #1;
    checks++; if (wdata !== 64'h5002) begin errors++; $display("FAIL t5_wdata2 got %h want 5002", wdata); end
    step();
    data[63:0] = 64'h5003;
    last = 4'b0001;
    #1;
    checks++; if (wen !== 1'b1) begin errors++; $display("FAIL t5_last_wen got %b want 1", wen); end
    step();
    checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL t5_idle got %b want 0000", grant); end
    checks++; if (pkt !== 16'd1) begin errors++; $display("FAIL t5_pkt got %0d want 1", pkt); end
    last = '0;
    step();
    checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL t5_next got %b want 0010", grant); end
    valid = '0;
  endtask

  task automatic test_enable();
    do_reset();
    valid = 4'b1000;
    data[3*64 +: 64] = 64'h6000;
    step();
    checks++; if (grant !== 4'b1000) begin errors++; $display("FAIL t6_grant got %b want 1000", grant); end
    enable = 1'b0;
    valid  = 4'b1010;
    #1;
    checks++; if (wen !== 1'b1) begin errors++; $display("FAIL t6_wen0 got %b want 1", wen); end
    step();
    data[3*64 +: 64] = 64'h6001;
    last = 4'b1000;
    #1;
    checks++; if (wdata !== 64'h6001) begin errors++; $display("FAIL t6_wdata1 got %h want 6001", wdata); end
    step();
    last  = '0;
    valid = 4'b0010;
    checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL t6_idle got %b want 0000", grant); end
    checks++; if (pkt !== 16'd1) begin errors++; $display("FAIL t6_pkt got %0d want 1", pkt); end
    step();
    step();
    checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL t6_blocked got %b want 0000", grant); end
    enable = 1'b1;
    step();
    checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL t6_regrant got %b want 0010", grant); end
    valid = '0;
  endtask

  initial begin
    rst_n  = 1'b0;
    enable = 1'b0;
    valid  = '0;
    last   = '0;
    data   = '0;
    rptr   = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_full();
    test_lock();
    test_enable();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

endmodule
